mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single read port of the 128x64 word memory between NREQ requesters.
- Each requester issues address requests on a valid/ready handshake and receives the 64-bit word on a valid/ready response channel.
- The block drives the memory address, waits MEM_LAT cycles for read data to settle, captures the word, and holds it until the requester accepts it.
- Sits between the memory array and the CPU-side clients (fetch, load unit, debug).

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 7, memory address width (128 words).
- DATA_W, 64, memory word width.
- MEM_LAT, 1, cycles mem_addr is held stable before mem_data is sampled (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- resp_valid  out  NREQ  one-hot response valid, registered.
- resp_data  out  DATA_W  shared response word, registered.
- resp_ready  in  NREQ  per-requester response accept.
- mem_addr  out  ADDR_W  address to the memory array, registered.
- mem_data  in  DATA_W  read data from the memory array.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant_q=0, last_grant=NREQ-1 (so requester 0 has first priority).
  - mem_addr=0, resp_data=0, resp_valid=0, busy=0, wait counter=0.
  - req_ready is forced to 0 while rst_n is low.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid, pick winner g by round-robin: first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - req_ready[g]=1 in that same cycle; handshake = req_valid[g] & req_ready[g].
  - At the clock edge: mem_addr<=req_addr[g], grant_q<=g, cnt<=0, state<=ACCESS.
  - If no req_valid, req_ready=0 and the block stays in IDLE.
- ACCESS:
  - mem_addr is held stable and cnt increments each cycle.
  - In the cycle where cnt==MEM_LAT-1: resp_data<=mem_data, resp_valid[grant_q]<=1, state<=RESP.
- RESP:
  - resp_valid[grant_q] and resp_data are held stable until resp_ready[grant_q]=1.
  - On that edge: resp_valid<=0, last_grant<=grant_q, state<=IDLE.
  - resp_ready on non-granted ports is ignored.
- Latency (MEM_LAT=1):
  - Accept in cycle t, resp_valid in cycle t+2.
  - Minimum issue interval is MEM_LAT+2 cycles (next accept no earlier than t+3).
  - One transaction in flight at a time; req_ready is 0 in ACCESS and RESP.
- Boundary conditions:
  - Simultaneous requests: only the winner is accepted; losers keep req_valid high and wait.
  - A requester may drop req_valid before it is granted without effect.
  - req_addr is sampled only at handshake; later changes are ignored.
  - Address range: all addresses 0..127 are legal, no range checking; mem_addr wraps naturally at ADDR_W.
  - Back-pressure: resp_ready held low stalls the block in RESP indefinitely with no new grants.
  - Same requester re-requesting: its next request is accepted only after its response completes, and only if no other requester is pending (rotation fairness).
  - Reset mid-operation: the transaction is aborted, no response is produced, and all outputs return to reset values immediately.
- Width rules:
  - Grant index width is clog2(NREQ).
  - resp_data is a straight copy of mem_data with no extension or masking.

Decomposition:
- Shared package / include mem_arb_pkg:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - ADDR_W=7 and DATA_W=64 defaults.
  - Idx-width function.
- Sub-module rr_arbiter (parameter NREQ):
  - Purely combinational.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant and its index, plus any_req.
  - Reused by later write-port arbitration.

Test Plan:
- Bench memory model returns mem_data = addr + 1000.
- Single request: req_valid[0]=1, req_addr[0]=20 at cycle 0 -> req_ready[0]=1 at cycle 0, mem_addr=20 at cycle 1, resp_valid=4'b0001 with resp_data=1020 at cycle 2; resp_ready[0]=1 -> busy=0 at cycle 3.
- Contention: requesters 0..3 all valid at once with addresses 111, 54, 45, 5 -> grants in order 0,1,2,3; responses 1111, 1054, 1045, 1005; each grant issued no earlier than 3 cycles after the previous.
- Fairness: requesters 1 and 3 continuously valid, last_grant=1 -> grant sequence 3,1,3,1; requester 1 is never granted twice in a row.
- Back-pressure: resp_ready[2] held low 10 cycles while requester 0 is valid -> resp_valid[2] and resp_data stable for all 10 cycles, req_ready=0 throughout; requester 0 is granted the cycle after resp_ready[2] rises.
- Reset mid-access: rst_n pulled low during ACCESS for address 127 -> resp_valid=0, mem_addr=0, busy=0 immediately; after release, requester 0 (still valid) is granted first and returns 1127.
- Address change: req_addr[1] changes from 10 to 99 the cycle after handshake -> response data is 1010.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and index-width helper for memory port arbiters
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 64;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/last_grant in, one-hot grant, grant_idx and any_req out
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);
  logic [IW-1:0] k;
  logic          found;
  always_comb begin
    k = '0;
    found = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IW'((int'(last_grant) + i) % NREQ);
      if (!found && req[k]) begin
        found = 1'b1;
        grant_idx = k;
      end
    end
    any_req = |req;
    grant = found ? NREQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one memory read port; req_valid/req_addr/req_ready in, resp_valid/resp_data/resp_ready out, mem_addr/mem_data to memory, busy status
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   busy
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(MEM_LAT);
  state_t          state;
  logic [IW-1:0]   grant_q, last_grant, g;
  logic [NREQ-1:0] grant;
  logic            any_req;
  logic [CW-1:0]   cnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .last_grant(last_grant),
    .grant(grant),
    .grant_idx(g),
    .any_req(any_req)
  );
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_q <= '0;
      last_grant <= IW'(NREQ - 1);
      mem_addr <= '0;
      resp_data <= '0;
      resp_valid <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          mem_addr <= req_addr[g*ADDR_W +: ADDR_W];
          grant_q <= g;
          cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: if (cnt == CW'(MEM_LAT - 1)) begin
          resp_data <= mem_data;
          resp_valid <= NREQ'(1) << grant_q;
          state <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (resp_ready[grant_q]) begin
          resp_valid <= '0;
          last_grant <= grant_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed self-checking bench for mem_read_arbiter with an addr+1000 memory model
module tb_mem_read_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [6:0]  addr [4];
  logic [27:0] req_addr;
  logic [3:0]  req_ready, resp_valid;
  logic [3:0]  resp_ready = '0;
  logic [63:0] resp_data, mem_data;
  logic [6:0]  mem_addr;
  logic        busy;
  int          n_chk = 0, n_fail = 0;
  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
  assign mem_data = 64'(mem_addr) + 64'd1000;
  always #5 clk = ~clk;
  mem_read_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input int g, input int exp_data, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    #1;
    check("grant", 64'(req_ready), 64'(oh));
    tick();
    if (drop) req_valid[g] = 1'b0;
    #1;
    check("mem_addr", 64'(mem_addr), 64'(addr[g]));
    check("ready_access", 64'(req_ready), 64'd0);
    tick();
    check("resp_valid", 64'(resp_valid), 64'(oh));
    check("resp_data", resp_data, 64'(exp_data));
    resp_ready = oh;
    tick();
    resp_ready = '0;
    check("idle_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) addr[i] = '0;
    repeat (2) tick();
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    addr[0] = 7'd20;
    req_valid = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    #1;
    check("single_mem_addr", 64'(mem_addr), 64'd20);
    check("single_busy", 64'(busy), 64'd1);
    check("single_no_resp", 64'(resp_valid), 64'd0);
    tick();
    check("single_resp_valid", 64'(resp_valid), 64'b0001);
    check("single_resp_data", resp_data, 64'd1020);
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    check("single_done_busy", 64'(busy), 64'd0);
    check("single_done_valid", 64'(resp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    addr[0] = 7'd111; addr[1] = 7'd54; addr[2] = 7'd45; addr[3] = 7'd5;
    req_valid = 4'b1111;
    xact(0, 1111, 1);
    xact(1, 1054, 1);
    xact(2, 1045, 1);
    xact(3, 1005, 1);
    addr[1] = 7'd10;
    req_valid = 4'b0010;
    #1;
    check("achg_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    addr[1] = 7'd99;
    #1;
    check("achg_mem_addr", 64'(mem_addr), 64'd10);
    tick();
    check("achg_resp_data", resp_data, 64'd1010);
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    addr[1] = 7'd30; addr[3] = 7'd70;
    req_valid = 4'b1010;
    xact(3, 1070, 0);
    xact(1, 1030, 0);
    xact(3, 1070, 0);
    xact(1, 1030, 0);
    req_valid = 4'b0100;
    addr[2] = 7'd2;
    #1;
    check("bp_grant", 64'(req_ready), 64'b0100);
    tick();
    addr[0] = 7'd7;
    req_valid = 4'b0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", 64'(resp_valid), 64'b0100);
      check("bp_resp_data", resp_data, 64'd1002);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 4'b0001;
    #1;
    check("bp_ignore_other", 64'(resp_valid), 64'b0100);
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    xact(0, 1007, 1);
    addr[0] = 7'd127;
    req_valid = 4'b0001;
    #1;
    check("rma_grant", 64'(req_ready), 64'b0001);
    tick();
    check("rma_mem_addr", 64'(mem_addr), 64'd127);
    rst_n = 1'b0;
    #1;
    check("rma_resp_valid", 64'(resp_valid), 64'd0);
    check("rma_mem_addr_rst", 64'(mem_addr), 64'd0);
    check("rma_busy", 64'(busy), 64'd0);
    check("rma_ready", 64'(req_ready), 64'd0);
    tick();
    check("rma_hold_resp", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    xact(0, 1127, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
